// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]          req;
    logic [1:0]          lock;
    logic [1:0]          we;
    logic [5:0]          op;
    logic [2*ADDR_W-1:0] addr;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          gnt;
    logic [1:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_din;
    logic [2:0]          mem_op;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_dout;
    modport master (
        output req, lock, we, op, addr, wdata, mem_dout,
        input  gnt, ack, rdata, mem_addr, mem_din, mem_op, mem_we
    );
    modport slave (
        input  req, lock, we, op, addr, wdata, mem_dout,
        output gnt, ack, rdata, mem_addr, mem_din, mem_op, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter with RMW lock for the data-memory port (option macro DMEM_ARB_FIXED_PRIO_EN)
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          last_gnt, lock_held, win, tie_win, start;

    // state register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    // pick the winner among current requests and sequence IDLE/ISSUE/WAIT/RESP
    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        tie_win = 1'b0;
`else
        tie_win = ~last_gnt;
`endif
        start = state == IDLE && |bus.req;
        win = (lock_held && bus.req[last_gnt]) ? last_gnt : &bus.req ? tie_win : bus.req[1];
        state_nx = state == IDLE  ? (start ? ISSUE : IDLE)
                 : state == ISSUE ? WAIT
                 : state == WAIT  ? (cnt == '0 ? RESP : WAIT)
                 : IDLE;
    end

    // registered memory request, latency count, read capture, ack and lock bookkeeping
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.gnt      <= '0;
            bus.ack      <= '0;
            bus.rdata    <= '0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.mem_op   <= '0;
            bus.mem_we   <= 1'b0;
            last_gnt     <= 1'b1;
            lock_held    <= 1'b0;
            cnt          <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            bus.ack    <= '0;
            if (start) begin
                bus.gnt      <= win ? 2'b10 : 2'b01;
                bus.mem_addr <= win ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
                bus.mem_din  <= win ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
                bus.mem_op   <= win ? bus.op[5:3] : bus.op[2:0];
                bus.mem_we   <= bus.we[win];
                last_gnt     <= win;
                cnt          <= CW'(MEM_LAT - 1);
            end
            if (state == WAIT) begin
                if (cnt == '0) begin
                    bus.rdata <= bus.mem_dout;
                    bus.ack   <= bus.gnt;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
            if (state == RESP) begin
                lock_held <= bus.lock[bus.gnt[1]];
                bus.gnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u1 (.clock(clk), .reset(reset), .bus(b1));
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u3 (.clock(clk), .reset(reset), .bus(b3));

    always #5 clk = ~clk;

    logic [DW-1:0] mem_arr [16];
    logic [DW-1:0] ref_mem [16];
    logic [1:0]    pending;
    logic          p_we [2];
    logic [2:0]    p_op [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wdata [2];
    logic          p_lock [2];
    int            m_last;
    logic          m_lock;

    function automatic logic [DW-1:0] init_val(input int i);
        return i == 4 ? 32'hDEADBEEF : 32'h1111_0000 + 32'(i) * 32'h0101;
    endfunction

    // memory behind the arbiter: stores on mem_we, reads combinationally by address
    always @(posedge clk) begin
        if (!reset) for (int i = 0; i < 16; i++) mem_arr[i] <= init_val(i);
        else if (b1.mem_we) mem_arr[b1.mem_addr[5:2]] <= b1.mem_din;
    end
    assign b1.mem_dout = mem_arr[b1.mem_addr[5:2]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // arbitration rules from the model's point of view
    function automatic int pick(input logic [1:0] r);
        if (m_lock && r[m_last]) return m_last;
        if (r == 2'b11) return FIXED ? 0 : 1 - m_last;
        return r[1] ? 1 : 0;
    endfunction

    task automatic drive();
        b1.req   = pending;
        b1.lock  = {p_lock[1], p_lock[0]};
        b1.we    = {p_we[1], p_we[0]};
        b1.op    = {p_op[1], p_op[0]};
        b1.addr  = {p_addr[1], p_addr[0]};
        b1.wdata = {p_wdata[1], p_wdata[0]};
    endtask

    task automatic model_reset();
        m_last = 1;
        m_lock = 1'b0;
        pending = 2'b00;
        for (int p = 0; p < 2; p++) begin
            p_we[p] = 1'b0; p_op[p] = 3'b0; p_addr[p] = '0; p_wdata[p] = '0; p_lock[p] = 1'b0;
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        drive();
    endtask

    task automatic set_txn(input int p, input logic we, input logic [2:0] op,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic lock);
        pending[p] = 1'b1;
        p_we[p] = we; p_op[p] = op; p_addr[p] = addr; p_wdata[p] = wdata; p_lock[p] = lock;
    endtask

    task automatic rand_txn(input int p);
        set_txn(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom()) & 32'hFFFF_FFFC,
                32'($urandom()), $urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset();
        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // one full transaction from an IDLE cycle with requests already driven; ends at the next IDLE cycle
    task automatic run_txn(input int want, output int w);
        logic [3:0]    idx;
        logic [DW-1:0] exp_rd;
        logic [1:0]    oh;
        w = pick(pending);
        oh = w == 1 ? 2'b10 : 2'b01;
        idx = p_addr[w][5:2];
        exp_rd = ref_mem[idx];
        @(negedge clk);
        if (want >= 0) chk("dir_gnt", b1.gnt, want == 1 ? 2 : 1);
        chk("issue_gnt", b1.gnt, oh);
        chk("issue_we", b1.mem_we, p_we[w]);
        chk("issue_addr", b1.mem_addr, p_addr[w]);
        chk("issue_op", b1.mem_op, p_op[w]);
        if (p_we[w]) chk("issue_din", b1.mem_din, p_wdata[w]);
        chk("issue_ack", b1.ack, 0);
        @(negedge clk);
        chk("wait_we", b1.mem_we, 0);
        chk("wait_ack", b1.ack, 0);
        chk("wait_gnt", b1.gnt, oh);
        @(negedge clk);
        chk("resp_ack", b1.ack, oh);
        chk("resp_gnt", b1.gnt, oh);
        chk("resp_we", b1.mem_we, 0);
        if (!p_we[w]) chk("resp_rdata", b1.rdata, exp_rd);
        else ref_mem[idx] = p_wdata[w];
        m_last = w;
        m_lock = p_lock[w];
        pending[w] = 1'b0;
        @(negedge clk);
        chk("idle_gnt", b1.gnt, 0);
        chk("idle_ack", b1.ack, 0);
    endtask

    initial begin
        int w;
        b3.req = '0; b3.lock = '0; b3.we = '0; b3.op = '0; b3.addr = '0; b3.wdata = '0; b3.mem_dout = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_gnt", b1.gnt, 0);
        chk("rst_ack", b1.ack, 0);
        chk("rst_rdata", b1.rdata, 0);
        chk("rst_addr", b1.mem_addr, 0);
        chk("rst_din", b1.mem_din, 0);
        chk("rst_op", b1.mem_op, 0);
        chk("rst_we", b1.mem_we, 0);
        chk("rst3_gnt", b3.gnt, 0);
        reset = 1'b1;

        set_txn(0, 1'b0, 3'b010, 32'h0000_0010, '0, 1'b0);
        drive();
        run_txn(0, w);
        set_txn(1, 1'b1, 3'b010, 32'h8000_0004, 32'h1234_5678, 1'b0);
        drive();
        run_txn(1, w);
        set_txn(0, 1'b0, 3'b010, 32'h0000_0004, '0, 1'b0);
        drive();
        run_txn(0, w);

        do_reset();
        set_txn(0, 1'b0, 3'b000, 32'h0000_0008, '0, 1'b0);
        set_txn(1, 1'b0, 3'b001, 32'h0000_000C, '0, 1'b0);
        drive();
        for (int i = 0; i < 4; i++) begin
            run_txn(FIXED ? 0 : i % 2, w);
            set_txn(w, 1'b0, 3'b010, 32'(16 + 4 * i), '0, 1'b0);
            drive();
        end

        do_reset();
        set_txn(1, 1'b0, 3'b010, 32'h0000_0020, '0, 1'b1);
        drive();
        run_txn(1, w);
        set_txn(0, 1'b0, 3'b001, 32'h0000_0030, '0, 1'b0);
        set_txn(1, 1'b1, 3'b010, 32'h0000_0024, 32'hCAFE_0001, 1'b1);
        drive();
        run_txn(1, w);
        drive();
        run_txn(0, w);

        set_txn(0, 1'b0, 3'b010, 32'h0000_0010, '0, 1'b0);
        drive();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rm_gnt", b1.gnt, 0);
        chk("rm_ack", b1.ack, 0);
        chk("rm_we", b1.mem_we, 0);
        chk("rm_rdata", b1.rdata, 0);
        chk("rm_addr", b1.mem_addr, 0);
        reset = 1'b1;
        model_reset();
        set_txn(0, 1'b0, 3'b010, 32'h0000_0010, '0, 1'b0);
        drive();
        run_txn(0, w);

        for (int r = 0; r < 150; r++) begin
            for (int p = 0; p < 2; p++) if (!pending[p] && $urandom_range(0, 1) == 1) rand_txn(p);
            drive();
            if (|pending) begin
                run_txn(-1, w);
            end else begin
                @(negedge clk);
                chk("rnd_idle_gnt", b1.gnt, 0);
            end
        end
        pending = 2'b00;
        drive();

        @(negedge clk);
        b3.req = 2'b01; b3.we = 2'b00; b3.op = 6'b000_010; b3.addr = {32'h0, 32'h0000_0040};
        b3.mem_dout = 32'hA000_0000;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("lat3_gnt", b3.gnt, 2'b01);
            chk("lat3_ack", b3.ack, c == 5 ? 2'b01 : 2'b00);
            if (c == 1) chk("lat3_addr", b3.mem_addr, 32'h0000_0040);
            if (c == 5) chk("lat3_rdata", b3.rdata, 32'hA000_0004);
            b3.mem_dout = 32'hA000_0000 + 32'(c);
        end
        b3.req = 2'b00;
        @(negedge clk);
        chk("lat3_idle_gnt", b3.gnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placing the single data-memory port (DataMem and the memory-mapped peripherals behind Mmu) between the Cpu data interface (port 0) and a secondary bus master (port 1, e.g. a DMA or loader engine). It grants one transaction at a time using round-robin with a lock for read-modify-write sequences. It issues registered address, data, op and write-enable to the memory side, captures read data after a fixed latency, and returns a one-cycle acknowledge. It sits between the masters and Mmu/DataMem in the top-level userspace section, on the same clock.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from issue until mem_dout is valid (≥1)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req  in  2  per-port request; bit p = port p
- lock  in  2  per-port lock; keep grant on the same port for the next transaction
- we  in  2  per-port write enable (1 = store)
- op  in  2×3  per-port memOp, port p at [3p+2:3p]
- addr  in  2×ADDR_W  per-port address
- wdata  in  2×DATA_W  per-port store data
- gnt  out  2  one-hot, port owning the current transaction
- ack  out  2  one-cycle completion pulse to the owning port
- rdata  out  DATA_W  registered read data, valid while ack is high
- mem_addr  out  ADDR_W  to Mmu/DataMem
- mem_din  out  DATA_W  store data
- mem_op  out  3  memOp
- mem_we  out  1  write strobe
- mem_dout  in  DATA_W  read data from Mmu

## Operation
- FSM states:
  - IDLE → ISSUE when any req is high; the winner's signals are latched into mem_* and gnt.
  - ISSUE → WAIT. mem_we is high only in ISSUE.
  - WAIT counts MEM_LAT−1 further cycles. When MEM_LAT=1, WAIT lasts one cycle.
  - WAIT → RESP. rdata is captured from mem_dout at this edge.
  - RESP → IDLE, always.
- Arbitration in IDLE:
  - If exactly one req is high, that port wins.
  - If both are high, the port not in last_gnt wins.
  - Exception: if lock[last_gnt] was high at the last ack and req[last_gnt] is high, last_gnt wins regardless.
- last_gnt updates on every grant. The lock value is sampled in the RESP cycle.
- Requester rules:
  - Hold req, we, op, addr and wdata stable from assertion through the ack cycle.
  - Deassert req in the cycle after ack unless a new transaction is wanted.
  - A req still high in IDLE is a new transaction.
- The arbiter does not modify data. Byte/half extension is done downstream per op.
- Writes follow the same path and latency as reads. rdata on a write ack is don't-care but is still registered.
- A req that drops before grant is ignored with no side effects.
- Reset values: state IDLE, gnt 0, ack 0, rdata 0, mem_addr 0, mem_din 0, mem_op 0, mem_we 0, last_gnt 1 (port 0 wins the first tie), lock memory 0.
- Reset asserted mid-transaction:
  - The arbiter is in IDLE and all outputs are at reset values from the next cycle.
  - No ack is produced.
  - A write whose ISSUE cycle coincided with the reset edge is not guaranteed to complete.

## Timing
- req sampled high in cycle 0:
  - gnt and mem_* are valid in cycle 1 (ISSUE).
  - ack and rdata are valid in cycle 2+MEM_LAT.
  - The next grant can issue in cycle 4+MEM_LAT.
- Throughput is one transaction per 3+MEM_LAT cycles.
- gnt stays high from ISSUE through RESP. ack is high for exactly one cycle, in RESP.
- Outputs are fully registered. There is no combinational path from req, addr or mem_dout to any output.
- Starvation bound: with lock held low, a requesting port waits at most one other transaction.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN
  - Defined: port 0 wins every tie and last_gnt is ignored for arbitration. Lock is still honored, so port 1 holding lock keeps the port.
  - Undefined: round-robin as in Operation.

## Test plan
- Single read: port 0 req, addr 0x00000010, op 010, MEM_LAT=1, mem_dout 0xDEADBEEF in cycle 2 → gnt=01 in cycles 1–3, ack[0] only in cycle 3, rdata=0xDEADBEEF.
- Single write: port 1 we=1, addr 0x80000004, wdata 0x12345678 → mem_we=1 only in cycle 1 with mem_addr/mem_din matching, ack[1] in cycle 3.
- Tie after reset: both req high continuously → grants alternate 0,1,0,1; with DMEM_ARB_FIXED_PRIO_EN defined → grants 0,0,0,0.
- Lock: port 1 lock=1 over two transactions while port 0 requests → grants 1,1,0; port 0's first grant is issued within 2 transactions after it requests.
- Reset mid-op: reset low in the WAIT cycle → next cycle gnt=0, ack=0, mem_we=0, rdata=0; a fresh port 0 req completes with normal 3-cycle latency.
- MEM_LAT=3: single read → ack in cycle 5, rdata equals mem_dout as presented in cycle 4.
